ps2_kbd_ctrl: RTL and testbench
===============================

Name: ps2_kbd_ctrl

Overview:
Controller that sits directly behind the PS/2 receiver. It drives the receiver's enable and consumes its received bytes. It decodes scan-code set 2 byte sequences (E0 extended prefix, F0 break prefix, E1 pause sequence) into single key events. Events are buffered in a small FIFO toward the consumer, and the block throttles the receiver when that FIFO is full.

Parameters:
FIFO_DEPTH, 8, event FIFO depth; power of 2, minimum 2.
TIMEOUT_CYCLES, 2000000, max clk cycles allowed between bytes of one multi-byte sequence (40 ms at 50 MHz).

Ports:
clk  in  1  system clock.
reset  in  1  active-low, synchronous reset, sampled on rising clk edge.
rx_idle  in  1  receiver is idle, i.e. between frames.
rx_done_tick  in  1  one-cycle pulse; rx_dout is valid in the same cycle.
rx_dout  in  8  received data byte.
rx_en  out  1  receiver enable; combinational, equals ~fifo_full.
ev_valid  out  1  event available (show-ahead FIFO head).
ev_ready  in  1  consumer accepts the event when ev_valid & ev_ready.
ev_code  out  8  scan code, with prefixes stripped.
ev_ext  out  1  event had an E0 prefix, or is a pause event.
ev_rel  out  1  event is a key release (break).
bat_ok  out  1  sticky; set when 0xAA is received.
err  out  1  sticky error flag.
err_clr  in  1  single-cycle pulse; clears err and bat_ok.

Behaviour:
- Reset (reset==0 at a clk edge): FSM goes to S_IDLE, FIFO is emptied, timeout counter and skip counter clear. bat_ok=0, err=0, ev_valid=0, ev_code/ev_ext/ev_rel=0, rx_en=1.
- Reset has priority over all other inputs. A frame in progress at reset is discarded. A byte arriving in the reset cycle is ignored.
- Bytes are processed only in cycles where rx_done_tick==1. When rx_done_tick==0, the FSM changes only through the timeout.
- FSM states: S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_PAUSE.
  - S_IDLE:
    - E0 -> S_EXT.
    - F0 -> S_BRK.
    - E1 -> S_PAUSE, with skip counter=7.
    - AA -> set bat_ok, stay.
    - 00, FC, FF -> set err, stay.
    - FA, FE -> ignored.
    - Any other byte b -> push {ext=0, rel=0, b}.
  - S_EXT: F0 -> S_EXT_BRK. E0 -> stay. Any other byte b -> push {1,0,b}, go to S_IDLE.
  - S_BRK: any byte b -> push {0,1,b}, go to S_IDLE.
  - S_EXT_BRK: any byte b -> push {1,1,b}, go to S_IDLE.
  - S_PAUSE: each byte decrements the skip counter. When the byte that takes the counter from 1 to 0 arrives, push {1,0,8'hE1} and go to S_IDLE. Byte contents are not checked.
- Timeout:
  - The counter runs in every non-IDLE state and clears on each rx_done_tick.
  - On reaching TIMEOUT_CYCLES-1: discard the partial sequence, set err, go to S_IDLE.
  - If a timeout and rx_done_tick coincide, the byte wins and the counter clears.
- Push latency: push occurs in the same cycle as rx_done_tick; ev_valid rises the next cycle if the FIFO was empty.
- FIFO behaviour:
  - Show-ahead; ev_code/ev_ext/ev_rel always equal the head entry.
  - Pop when ev_valid & ev_ready.
  - Push and pop in the same cycle: allowed when full (count unchanged) and when not empty.
  - Push and ready on an empty FIFO: only the push takes effect; there is no bypass.
  - When empty, outputs hold their last values, which are don't-care.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Count is $clog2(FIFO_DEPTH)+1 bits.
- Flow control:
  - rx_en = ~full. The receiver samples rx_en only at frame start, so a frame that has started always completes.
  - A push while full and not popping is dropped and sets err. This is unreachable in normal operation but must be handled.
- err_clr:
  - Clears both sticky flags.
  - If a set event and err_clr coincide, the set wins.

Optional Feature:
PS2_KBD_STATS_EN
- Defined: adds outputs ev_cnt[15:0] and drop_cnt[15:0].
  - ev_cnt counts successful pushes.
  - drop_cnt counts overflow drops plus timeout discards.
  - Both counters saturate at 16'hFFFF, clear on reset, and are not affected by err_clr.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package ps2_kbd_pkg holds:
  - typedef enum of the FSM states;
  - packed struct kbd_event_t {ext, rel, code[7:0]};
  - localparams for the special bytes: E0, F0, E1, AA, FA, FE, FC, 00, FF;
  - PAUSE_SKIP=7.
- Sub-module: ps2_kbd_fifo, a generic synchronous show-ahead FIFO of kbd_event_t, parameterised by depth.

Test Plan:
- Byte 1C -> one event {ext=0, rel=0, code=1C}. ev_valid rises the cycle after rx_done_tick.
- Bytes E0 F0 75 -> single event {1,1,75}. No events are emitted for the prefixes.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {1,0,E1}; the FSM is back in S_IDLE.
- Byte F0, then no byte for TIMEOUT_CYCLES (TIMEOUT_CYCLES set to 100) -> err=1, no event. A following 1C yields {0,0,1C}, not a release.
- With ev_ready=0, send 8 make codes (FIFO_DEPTH=8) -> rx_en=0 after the 8th. Then raise ev_ready -> the 8 events drain in order and rx_en returns to 1.
- Send AA then FF -> bat_ok=1 and err=1. An err_clr pulse clears both. Asserting reset mid-sequence (after E0) -> the next 1C yields {0,0,1C}.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 scan-code set 2 keyboard controller.
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BRK     = 3'd1,
        S_EXT     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } kbd_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } kbd_event_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_FC = 8'hFC;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FF = 8'hFF;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic kbd_event_t make_event(input logic ext, input logic rel, input logic [7:0] code);
        kbd_event_t ev;
        ev.ext  = ext;
        ev.rel  = rel;
        ev.code = code;
        return ev;
    endfunction

endpackage

// File: rtl/ps2_kbd_fifo.sv
// Synchronous show-ahead FIFO of key events; the head entry is always visible on dout.
module ps2_kbd_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  kbd_event_t din,
    input  logic       pop,
    output kbd_event_t dout,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    kbd_event_t      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign empty     = (count_r == (AW+1)'(0));
    assign full      = (count_r == FULL_CNT);
    assign do_pop_s  = pop & ~empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push_s = push & (~full | do_pop_s);
    assign overflow  = push & full & ~do_pop_s;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            else           wr_ptr_r <= wr_ptr_r;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            else           rd_ptr_r <= rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[rd_ptr_r] <= mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code set 2 decoder feeding an event FIFO, with receiver throttling.
// Optional statistics counters (ev_cnt, drop_cnt) are built when PS2_KBD_STATS_EN is defined.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_idle,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_dout,
    output logic       rx_en,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_rel,
    output logic       bat_ok,
    output logic       err,
    input  logic       err_clr
`ifdef PS2_KBD_STATS_EN
    ,
    output logic [15:0] ev_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    kbd_state_t  state_r, next_state_s;
    logic [2:0]  skip_r;
    logic [TW-1:0] tmo_cnt_r;
    logic        timeout_s;
    logic        push_s, set_bat_s, set_err_byte_s;
    kbd_event_t  push_ev_s, head_s;
    logic        fifo_full_s, fifo_empty_s, overflow_s;
    logic        bat_r, err_r;
    logic        unused_s;

    // rx_idle belongs to the receiver handshake but decoding does not need it.
    assign unused_s  = rx_idle;
    assign timeout_s = (state_r != S_IDLE) & ~rx_done_tick & (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_r <= S_IDLE;
        else        state_r <= next_state_s;
    end

    // Next-state decode of the prefix sequences.
    always_comb begin
        next_state_s = state_r;
        if (rx_done_tick) begin
            case (state_r)
                S_IDLE: begin
                    case (rx_dout)
                        BYTE_E0: next_state_s = S_EXT;
                        BYTE_F0: next_state_s = S_BRK;
                        BYTE_E1: next_state_s = S_PAUSE;
                        default: next_state_s = S_IDLE;
                    endcase
                end
                S_EXT: begin
                    if (rx_dout == BYTE_F0)      next_state_s = S_EXT_BRK;
                    else if (rx_dout == BYTE_E0) next_state_s = S_EXT;
                    else                         next_state_s = S_IDLE;
                end
                S_BRK, S_EXT_BRK: next_state_s = S_IDLE;
                S_PAUSE: begin
                    if (skip_r <= 3'd1) next_state_s = S_IDLE;
                    else                next_state_s = S_PAUSE;
                end
                default: next_state_s = S_IDLE;
            endcase
        end else if (timeout_s) begin
            next_state_s = S_IDLE;
        end else begin
            next_state_s = state_r;
        end
    end

    // Per-byte actions: event push and sticky-flag set requests.
    always_comb begin
        push_s         = 1'b0;
        push_ev_s      = '0;
        set_bat_s      = 1'b0;
        set_err_byte_s = 1'b0;
        if (rx_done_tick) begin
            case (state_r)
                S_IDLE: begin
                    case (rx_dout)
                        BYTE_E0, BYTE_F0, BYTE_E1, BYTE_FA, BYTE_FE: begin
                        end
                        BYTE_AA: set_bat_s = 1'b1;
                        BYTE_00, BYTE_FC, BYTE_FF: set_err_byte_s = 1'b1;
                        default: begin
                            push_s    = 1'b1;
                            push_ev_s = make_event(1'b0, 1'b0, rx_dout);
                        end
                    endcase
                end
                S_EXT: begin
                    if (rx_dout != BYTE_F0 && rx_dout != BYTE_E0) begin
                        push_s    = 1'b1;
                        push_ev_s = make_event(1'b1, 1'b0, rx_dout);
                    end else begin
                        push_s = 1'b0;
                    end
                end
                S_BRK: begin
                    push_s    = 1'b1;
                    push_ev_s = make_event(1'b0, 1'b1, rx_dout);
                end
                S_EXT_BRK: begin
                    push_s    = 1'b1;
                    push_ev_s = make_event(1'b1, 1'b1, rx_dout);
                end
                S_PAUSE: begin
                    if (skip_r <= 3'd1) begin
                        push_s    = 1'b1;
                        push_ev_s = make_event(1'b1, 1'b0, BYTE_E1);
                    end else begin
                        push_s = 1'b0;
                    end
                end
                default: push_s = 1'b0;
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // Pause-sequence skip counter.
    always_ff @(posedge clk) begin
        if (!reset)                                             skip_r <= 3'd0;
        else if (rx_done_tick && state_r == S_IDLE && rx_dout == BYTE_E1) skip_r <= PAUSE_SKIP;
        else if (rx_done_tick && state_r == S_PAUSE)            skip_r <= skip_r - 3'd1;
        else                                                    skip_r <= skip_r;
    end

    // Inter-byte timeout counter; only advances mid-sequence.
    always_ff @(posedge clk) begin
        if (!reset)                                          tmo_cnt_r <= TW'(0);
        else if (rx_done_tick || state_r == S_IDLE || timeout_s) tmo_cnt_r <= TW'(0);
        else                                                 tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end

    // Sticky flags; a coinciding set beats err_clr.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bat_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (set_bat_s)    bat_r <= 1'b1;
            else if (err_clr) bat_r <= 1'b0;
            else              bat_r <= bat_r;
            if (set_err_byte_s || timeout_s || overflow_s) err_r <= 1'b1;
            else if (err_clr)                               err_r <= 1'b0;
            else                                            err_r <= err_r;
        end
    end

    ps2_kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_s),
        .din      (push_ev_s),
        .pop      (ev_ready),
        .dout     (head_s),
        .empty    (fifo_empty_s),
        .full     (fifo_full_s),
        .overflow (overflow_s)
    );

    assign rx_en    = ~fifo_full_s;
    assign ev_valid = ~fifo_empty_s;
    assign ev_code  = head_s.code;
    assign ev_ext   = head_s.ext;
    assign ev_rel   = head_s.rel;
    assign bat_ok   = bat_r;
    assign err      = err_r;

`ifdef PS2_KBD_STATS_EN
    logic [15:0] ev_cnt_r, drop_cnt_r;

    // Saturating event and drop statistics; overflow and timeout never coincide.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ev_cnt_r   <= 16'd0;
            drop_cnt_r <= 16'd0;
        end else begin
            if (push_s && !overflow_s && ev_cnt_r != 16'hFFFF) ev_cnt_r <= ev_cnt_r + 16'd1;
            else                                               ev_cnt_r <= ev_cnt_r;
            if ((overflow_s || timeout_s) && drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
            else                                                     drop_cnt_r <= drop_cnt_r;
        end
    end

    assign ev_cnt   = ev_cnt_r;
    assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed scenarios plus randomized byte streams vs. a queue model.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_idle = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       ev_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       rx_en, ev_valid, ev_ext, ev_rel, bat_ok, err;
    logic [7:0] ev_code;
`ifdef PS2_KBD_STATS_EN
    logic [15:0] ev_cnt, drop_cnt;
`endif

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_idle      (rx_idle),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .rx_en        (rx_en),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_rel       (ev_rel),
        .bat_ok       (bat_ok),
        .err          (err),
        .err_clr      (err_clr)
`ifdef PS2_KBD_STATS_EN
        ,
        .ev_cnt       (ev_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: pending prefix flags and the expected FIFO contents {ext,rel,code}.
    logic [9:0] mq[$];
    bit m_bat, m_err, m_ext, m_brk;
    int m_pause, m_gap, m_evc, m_drc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst_n, input logic tick, input logic [7:0] b,
                              input logic rdy, input logic clr);
        bit do_push, set_err, set_bat, pop, in_seq;
        logic [9:0] e;
        int sz;
        do_push = 1'b0; set_err = 1'b0; set_bat = 1'b0; e = 10'h000;
        if (!rst_n) begin
            mq.delete();
            m_bat = 1'b0; m_err = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
            m_pause = 0; m_gap = 0; m_evc = 0; m_drc = 0;
            return;
        end
        in_seq = m_ext || m_brk || (m_pause > 0);
        sz  = mq.size();
        pop = (sz != 0) && rdy;
        if (tick) begin
            m_gap = 0;
            if (m_pause > 0) begin
                m_pause--;
                if (m_pause == 0) begin do_push = 1'b1; e = {2'b10, 8'hE1}; end
            end else if (m_brk) begin
                do_push = 1'b1; e = {m_ext, 1'b1, b}; m_ext = 1'b0; m_brk = 1'b0;
            end else if (m_ext) begin
                if (b == 8'hF0) m_brk = 1'b1;
                else if (b != 8'hE0) begin do_push = 1'b1; e = {2'b10, b}; m_ext = 1'b0; end
            end else begin
                case (b)
                    8'hE0: m_ext = 1'b1;
                    8'hF0: m_brk = 1'b1;
                    8'hE1: m_pause = 7;
                    8'hAA: set_bat = 1'b1;
                    8'h00, 8'hFC, 8'hFF: set_err = 1'b1;
                    8'hFA, 8'hFE: ;
                    default: begin do_push = 1'b1; e = {2'b00, b}; end
                endcase
            end
        end else if (in_seq) begin
            m_gap++;
            if (m_gap == TMO) begin
                m_ext = 1'b0; m_brk = 1'b0; m_pause = 0; m_gap = 0;
                set_err = 1'b1; if (m_drc < 65535) m_drc++;
            end
        end
        if (pop) void'(mq.pop_front());
        if (do_push) begin
            if (sz < DEPTH || pop) begin
                mq.push_back(e);
                if (m_evc < 65535) m_evc++;
            end else begin
                set_err = 1'b1;
                if (m_drc < 65535) m_drc++;
            end
        end
        m_err = (m_err && !clr) || set_err;
        m_bat = (m_bat && !clr) || set_bat;
    endtask

    task automatic drive(input logic rst_n, input logic tick, input logic [7:0] b,
                         input logic rdy, input logic clr);
        #1;
        reset = rst_n; rx_done_tick = tick; rx_dout = b; ev_ready = rdy; err_clr = clr;
        model_step(rst_n, tick, b, rdy, clr);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        drive(1'b1, 1'b1, b, rdy, 1'b0);
        drive(1'b1, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ev_valid", ev_valid, mq.size() != 0);
            if (mq.size() != 0) check("ev_head", {ev_ext, ev_rel, ev_code}, mq[0]);
            check("rx_en", rx_en, mq.size() != DEPTH);
            check("bat_ok", bat_ok, m_bat);
            check("err", err, m_err);
`ifdef PS2_KBD_STATS_EN
            check("ev_cnt", ev_cnt, m_evc);
            check("drop_cnt", drop_cnt, m_drc);
`endif
        end
    end

    logic [7:0] specials [9] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hFC, 8'h00, 8'hFF};

    initial begin
        logic rdy_mode_r;
        int mode;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h1C, 1'b1, 1'b0);
        chk_en = 1'b1;
        check("rst_ev_valid", ev_valid, 1'b0);
        check("rst_ev_head", {ev_ext, ev_rel, ev_code}, 10'h000);
        check("rst_rx_en", rx_en, 1'b1);
        check("rst_flags", {bat_ok, err}, 2'b00);

        // Single make code and push latency.
        idle(2, 1'b0);
        check("pre_push_valid", ev_valid, 1'b0);
        drive(1'b1, 1'b1, 8'h1C, 1'b0, 1'b0);
        check("push_latency_valid", ev_valid, 1'b1);
        check("make_1c", {ev_ext, ev_rel, ev_code}, 10'h01C);
        idle(3, 1'b1);

        // Extended break.
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        check("ext_brk_75", {ev_ext, ev_rel, ev_code}, 10'h375);
        idle(3, 1'b1);

        // Pause sequence.
        send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
        send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0); send(8'h77, 1'b0);
        check("pause_event", {ev_ext, ev_rel, ev_code}, 10'h2E1);
        idle(3, 1'b1);
        send(8'h1C, 1'b0);
        check("after_pause_idle", {ev_ext, ev_rel, ev_code}, 10'h01C);
        idle(3, 1'b1);

        // Timeout after a break prefix.
        send(8'hF0, 1'b0);
        idle(150, 1'b0);
        check("timeout_err", err, 1'b1);
        check("timeout_no_event", ev_valid, 1'b0);
        send(8'h1C, 1'b0);
        check("after_timeout_make", {ev_ext, ev_rel, ev_code}, 10'h01C);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Fill the FIFO, then drain in order.
        for (int i = 0; i < DEPTH; i++) send(8'h15 + 8'(i), 1'b0);
        check("full_rx_en", rx_en, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", {ev_ext, ev_rel, ev_code}, {2'b00, 8'h15 + 8'(i)});
            drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drained_rx_en", rx_en, 1'b1);
        check("drained_valid", ev_valid, 1'b0);

        // BAT / error flags, err_clr, and reset mid-sequence.
        send(8'hAA, 1'b0); send(8'hFF, 1'b0);
        check("bat_err_set", {bat_ok, err}, 2'b11);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("err_clr", {bat_ok, err}, 2'b00);
        send(8'hE0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send(8'h1C, 1'b0);
        check("reset_mid_seq", {ev_ext, ev_rel, ev_code}, 10'h01C);
        idle(3, 1'b1);

        // Randomized byte streams with varying consumer behaviour.
        mode = 0;
        rdy_mode_r = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            logic tick, rdy, clr, rst_n;
            logic [7:0] b;
            if (c % 250 == 0) mode = $urandom_range(0, 2);
            rdy   = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick  = ($urandom_range(0, 3) == 0);
            b     = ($urandom_range(0, 9) < 4) ? specials[$urandom_range(0, 8)] : 8'($urandom);
            clr   = ($urandom_range(0, 63) == 0);
            rst_n = ($urandom_range(0, 1999) != 0);
            rdy_mode_r = rdy;
            drive(rst_n, tick, b, rdy_mode_r, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
